// File: rtl/jtframe_sdram_rd32.sv
// Single-bank SDRAM reader: power-up init sequence, then 32-bit reads built from
// a burst-2 / CL2 pair of 16-bit words, with periodic auto-refresh between reads.
module jtframe_sdram_rd32 #(
  parameter int         SDRAMW     = 22,
  parameter logic [1:0] BA         = 2'd0,
  parameter int         INIT_WAIT  = 9600,
  parameter int         REF_PERIOD = 360,
  parameter int         RFC        = 7
) (
  input  logic              clk,
  input  logic              rst,
  // req/ack: req is a level held by the arbiter; ack pulses for one cycle when
  // addr is latched, and the arbiter drops req (or changes addr) after seeing it.
  input  logic              req,
  input  logic [SDRAMW-1:0] addr,
  output logic              ack,
  output logic              data_rdy,
  output logic [31:0]       data_read,
  output logic              init_done,
  input  logic [15:0]       sdram_din,
  output logic [12:0]       sdram_a,
  output logic [1:0]        sdram_ba,
  output logic              sdram_ncs,
  output logic              sdram_nras,
  output logic              sdram_ncas,
  output logic              sdram_nwe,
  output logic              sdram_cke,
  output logic [1:0]        sdram_dqm,
  output logic [3:0]        dbg_state_o
);

  localparam logic [3:0] ST_INIT     = 4'd0;
  localparam logic [3:0] ST_IDLE     = 4'd1;
  localparam logic [3:0] ST_ACT_WAIT = 4'd2;
  localparam logic [3:0] ST_READ     = 4'd3;
  localparam logic [3:0] ST_CAS_WAIT = 4'd4;
  localparam logic [3:0] ST_CAP_LO   = 4'd5;
  localparam logic [3:0] ST_CAP_HI   = 4'd6;
  localparam logic [3:0] ST_DONE     = 4'd7;
  localparam logic [3:0] ST_REFRESH  = 4'd8;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam int INIT_END = INIT_WAIT + 4 + 2 * RFC;
  localparam int CW       = $clog2(INIT_END + 1);
  localparam int RW       = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [12:0]   a_q, a_d;
  logic [1:0]    ba_q, ba_d;
  logic          cke_q, cke_d;
  logic [1:0]    dqm_q, dqm_d;
  logic          ack_q, ack_d;
  logic          rdy_q, rdy_d;
  logic [31:0]   data_q, data_d;
  logic          done_q, done_d;
  logic [8:0]    col_q, col_d;
  logic [15:0]   lo_q, lo_d;
  logic [15:0]   hi_q, hi_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          pend_q, pend_d;
  logic          wrap, ref_go;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = CMD_NOP;
    a_d     = a_q;
    ba_d    = BA;
    cke_d   = 1'b1;
    dqm_d   = dqm_q;
    ack_d   = 1'b0;
    rdy_d   = 1'b0;
    data_d  = data_q;
    done_d  = done_q;
    col_d   = col_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    ref_go  = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(INIT_WAIT)) begin
          cmd_d = CMD_PRE;
          a_d   = 13'h0400;
        end else if (cnt_q == CW'(INIT_WAIT + 2) || cnt_q == CW'(INIT_WAIT + 2 + RFC)) begin
          cmd_d = CMD_REF;
        end else if (cnt_q == CW'(INIT_WAIT + 2 + 2 * RFC)) begin
          cmd_d = CMD_MRS;
          a_d   = 13'h0021;
        end else if (cnt_q == CW'(INIT_END)) begin
          done_d  = 1'b1;
          dqm_d   = 2'b00;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // a pending refresh always wins over a simultaneous request
        if (pend_q) begin
          cmd_d   = CMD_REF;
          ref_go  = 1'b1;
          cnt_d   = '0;
          state_d = ST_REFRESH;
        end else if (req) begin
          cmd_d   = CMD_ACT;
          a_d     = 13'(addr >> 9);
          col_d   = addr[8:0];
          ack_d   = 1'b1;
          state_d = ST_ACT_WAIT;
        end
      end
      ST_ACT_WAIT: state_d = ST_READ;
      ST_READ: begin
        cmd_d   = CMD_RD;
        a_d     = {2'b00, 1'b1, 1'b0, col_q};
        cnt_d   = '0;
        state_d = ST_CAS_WAIT;
      end
      ST_CAS_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_CAP_LO;
      end
      ST_CAP_LO: begin
        lo_d    = sdram_din;
        state_d = ST_CAP_HI;
      end
      ST_CAP_HI: begin
        hi_d    = sdram_din;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        data_d  = {hi_q, lo_q};
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_REFRESH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(RFC - 2)) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    wrap = done_q && (rcnt_q == RW'(REF_PERIOD - 1));
    if (!done_q)   rcnt_d = rcnt_q;
    else if (wrap) rcnt_d = '0;
    else           rcnt_d = rcnt_q + 1'b1;
    // a wrap while already pending does not queue a second refresh
    if (wrap)        pend_d = 1'b1;
    else if (ref_go) pend_d = 1'b0;
    else             pend_d = pend_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      cmd_q   <= CMD_NOP;
      a_q     <= '0;
      ba_q    <= '0;
      cke_q   <= 1'b0;
      dqm_q   <= 2'b11;
      ack_q   <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      col_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      ba_q    <= ba_d;
      cke_q   <= cke_d;
      dqm_q   <= dqm_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      done_q  <= done_d;
      col_q   <= col_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
    end
  end

  assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd_q;
  assign sdram_a     = a_q;
  assign sdram_ba    = ba_q;
  assign sdram_cke   = cke_q;
  assign sdram_dqm   = dqm_q;
  assign ack         = ack_q;
  assign data_rdy    = rdy_q;
  assign data_read   = data_q;
  assign init_done   = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/jtframe_sdram_rd32.md
JTFRAME_SDRAM_RD32 -- requirements
Module: jtframe_sdram_rd32

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- SDRAMW, 22, word address width; row = addr[21:9], column = addr[8:0].
- BA, 2'd0, fixed SDRAM bank driven on sdram_ba.
- INIT_WAIT, 9600, power-up NOP cycles before the init sequence.
- REF_PERIOD, 360, cycles between refresh requests.
- RFC, 7, cycles (inclusive of command) for REF and for the post-REF wait.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- req, in, 1, read request from the slot arbiter.
- addr, in, SDRAMW, 16-bit-word address of the 32-bit read.
- ack, out, 1, one-cycle pulse; request accepted, addr latched.
- data_rdy, out, 1, one-cycle pulse; data_read valid.
- data_read, out, 32, {word at addr+1, word at addr}.
- init_done, out, 1, high once the init sequence has finished.
- sdram_din, in, 16, SDRAM DQ input.
- sdram_a, out, 13, SDRAM address.
- sdram_ba, out, 2, SDRAM bank.
- sdram_ncs / sdram_nras / sdram_ncas / sdram_nwe, out, 1 each, command pins.
- sdram_cke, out, 1, clock enable.
- sdram_dqm, out, 2, data mask.

Function
REQ-003 Commands SHALL be encoded as {ncs,nras,ncas,nwe}: NOP 0111, ACT 0011, READ 0101, PRE 0010, REF 0001, MRS 0000.
- All command, address and bank outputs SHALL be registered.
REQ-004 Init SHALL run as follows, with NOP on every cycle not named:
- INIT_WAIT cycles of NOP.
- PRE with A10=1.
- 2 cycles later, REF.
- RFC cycles later, a second REF.
- RFC cycles later, MRS with sdram_a=13'h0021 (burst length 2, sequential, CL2).
- 2 cycles later, init_done=1 (stays high until rst).
REQ-005 Before init_done, req SHALL be ignored and ack, data_rdy SHALL remain 0.
REQ-006 Control SHALL be one FSM with states INIT, IDLE, ACT_WAIT, READ, CAS_WAIT, CAP_LO, CAP_HI, DONE, REFRESH.
REQ-007 In IDLE with a refresh pending, the FSM SHALL issue REF, go to REFRESH for RFC cycles, then return to IDLE.
- Refresh SHALL win over a simultaneous req.
REQ-008 In IDLE with req=1 and no refresh pending (cycle N), the block SHALL:
- issue ACT with sdram_a=addr[21:9];
- latch addr;
- assert ack for exactly one cycle.
REQ-009 A read SHALL follow this cycle-level timing:
- N+1: NOP.
- N+2: READ with sdram_a={2'b00, 1'b1 (auto-precharge), 1'b0, addr[8:0]}.
- N+5: low word captured from sdram_din (CL2 plus input register).
- N+6: high word captured.
- N+7: data_rdy=1 and data_read updated.
- N+8: FSM back in IDLE; the earliest next ACT is at N+8 (covers tRP).
REQ-010 data_read SHALL hold its value until the next data_rdy.
- Changes on addr or req after ack SHALL NOT affect an access in flight.
REQ-011 If req is still high in IDLE at N+8, a new access SHALL start; the arbiter handshake (req dropped on ack) SHALL give exactly one access per request.
REQ-012 The refresh counter SHALL count from 0 to REF_PERIOD-1 and wrap.
- It SHALL start counting when init_done rises.
- On wrap it SHALL set refresh_pending; issuing REF clears it.
- A wrap while pending is already set SHALL NOT queue a second refresh.
REQ-013 A refresh becoming due during a read SHALL wait until IDLE; reads SHALL NOT be aborted.
REQ-014 sdram_dqm SHALL be 2'b11 until init_done, then 2'b00.
REQ-015 sdram_ba SHALL equal BA on every command after reset.

Reset
REQ-016 While rst=1 the outputs SHALL be:
- command NOP;
- sdram_cke=0, sdram_a=0, sdram_ba=0, sdram_dqm=2'b11;
- ack=0, data_rdy=0, data_read=0, init_done=0.
- The refresh counter and refresh_pending SHALL clear.
REQ-017 A reset asserted mid-read or mid-refresh SHALL discard the operation with no data_rdy, then restart from INIT.
- sdram_cke=1 on the first cycle after rst falls.

Verification
REQ-018 Init: release rst with INIT_WAIT=16, RFC=7 -> PRE at cycle 16, REF at 18 and 25, MRS a=0x0021 at 32, init_done=1 at 34, no ack throughout.
REQ-019 Single read: SDRAM model holding 0x1234 at 0x00A05 and 0xABCD at 0x00A06, req with addr=0x00A05 at cycle N -> ACT row 0x005 at N, READ a=0x405 at N+2, data_rdy with data_read=0xABCD1234 at N+7.
REQ-020 Back-to-back: req held high across two accesses with addr changed after the first ack -> two ACTs exactly 8 cycles apart, second data from the new address.
REQ-021 Refresh collision: refresh_pending set on the same cycle req rises in IDLE -> REF first, ACT RFC cycles later, one ack total.
REQ-022 Refresh during read: counter wraps at N+3 of a read -> read completes at N+7, REF at N+8.
REQ-023 Mid-op reset: rst pulsed at N+4 of a read -> no data_rdy, outputs at REQ-016 values, full init sequence repeated.
